// File: rtl/nv_nvdla_csb_pkg.sv
// Shared CSB definitions: request/response payload field positions, response
// type encodings and the initiator state enum.
package nv_nvdla_csb_pkg;

   localparam int unsigned REQ_PD_W      = 63;
   localparam int unsigned REQ_ADDR_LSB  = 0;
   localparam int unsigned REQ_ADDR_W    = 22;
   localparam int unsigned REQ_WDAT_LSB  = 22;
   localparam int unsigned REQ_WDAT_W    = 32;
   localparam int unsigned REQ_WRITE     = 54;
   localparam int unsigned REQ_NPOSTED   = 55;
   localparam int unsigned REQ_SRCPRIV   = 56;
   localparam int unsigned REQ_WRBE_LSB  = 57;
   localparam int unsigned REQ_WRBE_W    = 4;
   localparam int unsigned REQ_LEVEL_LSB = 61;
   localparam int unsigned REQ_LEVEL_W   = 2;

   localparam int unsigned RESP_PD_W      = 34;
   localparam int unsigned RESP_RDATA_LSB = 0;
   localparam int unsigned RESP_RDATA_W   = 32;
   localparam int unsigned RESP_ERROR     = 32;
   localparam int unsigned RESP_TYPE      = 33;

   localparam logic RESP_TYPE_READ  = 1'b0;
   localparam logic RESP_TYPE_WRITE = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_REQ       = 2'd1,
      ST_WAIT_RESP = 2'd2,
      ST_DONE      = 2'd3
   } csb_state_e;

endpackage

// File: rtl/nv_nvdla_csb_req_pack.sv
// Combinational packing of a host register command into a CSB request payload.
module nv_nvdla_csb_req_pack
   import nv_nvdla_csb_pkg::*;
(
   input  logic [21:0]         addr,
   input  logic [31:0]         wdat,
   input  logic                write,
   input  logic                nposted,
   output logic [REQ_PD_W-1:0] pd
);

   always_comb begin
      pd = '0;
      pd[REQ_ADDR_LSB +: REQ_ADDR_W]   = addr;
      pd[REQ_WDAT_LSB +: REQ_WDAT_W]   = wdat;
      pd[REQ_WRITE]                    = write;
      pd[REQ_NPOSTED]                  = nposted;
      pd[REQ_SRCPRIV]                  = 1'b0;
      pd[REQ_WRBE_LSB +: REQ_WRBE_W]   = '1;
      pd[REQ_LEVEL_LSB +: REQ_LEVEL_W] = '0;
   end

endmodule

// File: rtl/nv_nvdla_csb_initiator.sv
// Single-outstanding CSB request initiator with response timeout and
// one-cycle host completion pulse.
module nv_nvdla_csb_initiator
   import nv_nvdla_csb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                 nvdla_core_clk,
   input  logic                 nvdla_core_rstn,
   input  logic                 host_req_valid,
   output logic                 host_req_ready,
   input  logic [21:0]          host_req_addr,
   input  logic [31:0]          host_req_wdat,
   input  logic                 host_req_write,
   input  logic                 host_req_nposted,
   output logic                 host_resp_valid,
   output logic [31:0]          host_resp_rdat,
   output logic                 host_resp_err,
   output logic                 host_resp_timeout,
   output logic                 spurious_resp,
   output logic                 csb_req_pvld,
   input  logic                 csb_req_prdy,
   output logic [REQ_PD_W-1:0]  csb_req_pd,
   input  logic                 csb_resp_valid,
   input  logic [RESP_PD_W-1:0] csb_resp_pd
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   csb_state_e state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic          write_q, nposted_q;
   logic          nposted_eff;
   logic [REQ_PD_W-1:0] pd_next;

   logic        accept, req_hs, resp_hit, expire;
   logic        resp_err_d, resp_to_d;
   logic [31:0] resp_rdat_d;

   assign nposted_eff = host_req_nposted | ~host_req_write;
   assign accept      = (state_q == ST_IDLE) && host_req_valid;
   assign req_hs      = (state_q == ST_REQ) && csb_req_prdy;
   assign resp_hit    = (state_q == ST_WAIT_RESP) && csb_resp_valid;
   assign expire      = (state_q == ST_WAIT_RESP) && !csb_resp_valid && (cnt_q == CNT_LAST);

   // Payload is packed at accept time so the CSB side only ever sees registers.
   nv_nvdla_csb_req_pack u_req_pack (
      .addr    (host_req_addr),
      .wdat    (host_req_wdat),
      .write   (host_req_write),
      .nposted (nposted_eff),
      .pd      (pd_next)
   );

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) state_q <= ST_IDLE;
      else                  state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:      if (host_req_valid) state_d = ST_REQ;
         ST_REQ:       if (csb_req_prdy)
                          state_d = (write_q && !nposted_q) ? ST_DONE : ST_WAIT_RESP;
         ST_WAIT_RESP: if (csb_resp_valid || expire) state_d = ST_DONE;
         ST_DONE:      state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      host_req_ready = (state_q == ST_IDLE);
      resp_err_d     = 1'b0;
      resp_to_d      = 1'b0;
      resp_rdat_d    = '0;
      if (resp_hit) begin
         resp_err_d = csb_resp_pd[RESP_ERROR] |
                      (csb_resp_pd[RESP_TYPE] != (write_q ? RESP_TYPE_WRITE : RESP_TYPE_READ));
         if (!resp_err_d && !write_q)
            resp_rdat_d = csb_resp_pd[RESP_RDATA_LSB +: RESP_RDATA_W];
      end else if (expire) begin
         resp_err_d = 1'b1;
         resp_to_d  = 1'b1;
      end
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         write_q           <= 1'b0;
         nposted_q         <= 1'b0;
         csb_req_pd        <= '0;
         csb_req_pvld      <= 1'b0;
         cnt_q             <= '0;
         host_resp_valid   <= 1'b0;
         host_resp_rdat    <= '0;
         host_resp_err     <= 1'b0;
         host_resp_timeout <= 1'b0;
         spurious_resp     <= 1'b0;
      end else begin
         if (accept) begin
            write_q    <= host_req_write;
            nposted_q  <= nposted_eff;
            csb_req_pd <= pd_next;
         end
         if (accept)      csb_req_pvld <= 1'b1;
         else if (req_hs) csb_req_pvld <= 1'b0;

         if (req_hs)
            cnt_q <= '0;
         else if ((state_q == ST_WAIT_RESP) && (cnt_q != CNT_MAX))
            cnt_q <= cnt_q + 1'b1;

         host_resp_valid   <= (state_d == ST_DONE);
         host_resp_rdat    <= resp_rdat_d;
         host_resp_err     <= resp_err_d;
         host_resp_timeout <= resp_to_d;

         if (csb_resp_valid && (state_q != ST_WAIT_RESP))
            spurious_resp <= 1'b1;
      end
   end

endmodule

// File: doc/nv_nvdla_csb_initiator.md
# nv_nvdla_csb_initiator

Single-outstanding CSB request initiator: the requesting end of the CSB register-access interface that the configuration ROM and other CSB targets respond to. It accepts one host register command at a time and packs it into a 63-bit CSB request under a valid/ready handshake. It then tracks the unhandshaked 34-bit response, with a timeout, and returns the result to the host as a one-cycle completion pulse. It sits between a host-side register bridge and one CSB target port.

## Interface
- TIMEOUT_CYCLES, 255: WAIT_RESP cycles before a non-posted access is abandoned (1..65535).
- nvdla_core_clk  in  1  sole clock.
- nvdla_core_rstn  in  1  asynchronous, active-low reset.
- host_req_valid  in  1  host command valid.
- host_req_ready  out  1  block can accept a command (IDLE only).
- host_req_addr  in  22  CSB word address.
- host_req_wdat  in  32  write data.
- host_req_write  in  1  1 = write, 0 = read.
- host_req_nposted  in  1  write only: 1 = non-posted, so a response is expected.
- host_resp_valid  out  1  one-cycle completion pulse; no back-pressure.
- host_resp_rdat  out  32  read data; 0 for writes, errors and timeouts.
- host_resp_err  out  1  target error bit, or response-type mismatch.
- host_resp_timeout  out  1  completion caused by the timeout.
- spurious_resp  out  1  sticky flag: a response arrived when none was expected; cleared only by reset.
- csb_req_pvld  out  1  CSB request valid.
- csb_req_prdy  in  1  CSB request ready.
- csb_req_pd  out  63  request payload. Bit fields:
  - [21:0] addr
  - [53:22] wdat
  - [54] write
  - [55] nposted
  - [56] srcpriv = 0
  - [60:57] wrbe = 4'hF
  - [62:61] level = 0
- csb_resp_valid  in  1  response valid, single cycle, no ready.
- csb_resp_pd  in  34  response payload. Bit fields:
  - [31:0] rdata
  - [32] error
  - [33] type: 0 = read response, 1 = write response

## Operation
- FSM states: IDLE, REQ, WAIT_RESP, DONE.
- IDLE:
  - host_req_ready=1.
  - On host_req_valid, register addr, wdat, write and effective nposted, then go to REQ.
  - Effective nposted is forced to 1 for reads.
- REQ:
  - csb_req_pvld=1; csb_req_pd is driven from registers only.
  - pd is held stable until csb_req_prdy=1.
  - On handshake: a posted write (write=1, nposted=0) goes to DONE with success status. Any other access clears the timeout counter and goes to WAIT_RESP.
- WAIT_RESP: the counter increments each cycle.
  - On csb_resp_valid: capture the response and go to DONE.
    - err = pd[32] OR (pd[33] != write).
    - rdat = pd[31:0] for an error-free read, else 0.
  - Timeout: when the counter reaches TIMEOUT_CYCLES-1 with no response, go to DONE with timeout=1, err=1, rdat=0.
  - csb_resp_valid in the same cycle as expiry counts as the response; the timeout is not taken.
- DONE:
  - host_resp_valid=1 for exactly one cycle, together with the captured rdat, err and timeout.
  - Then go to IDLE.
- csb_resp_valid in IDLE, REQ or DONE:
  - Response is dropped and spurious_resp is set.
  - This includes late responses after a timeout.
- Counter width is $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.

## Timing
- Reset values:
  - State = IDLE and counter = 0.
  - host_req_ready=1 (combinational from IDLE).
  - csb_req_pvld=0, csb_req_pd=0.
  - host_resp_valid=0, host_resp_rdat=0, host_resp_err=0, host_resp_timeout=0.
  - spurious_resp=0.
- All outputs are registered except host_req_ready, which is decoded from the state register.
- Latency, host accept to csb_req_pvld: 1 cycle.
- Latency, CSB accept to host_resp_valid:
  - Posted write: 1 cycle.
  - Response-bearing access: response cycle + 1.
- Minimum command-to-command spacing: 3 cycles for a posted write with immediate prdy.
- Reset asserted mid-transaction:
  - All state clears immediately (asynchronous).
  - No completion is reported.
  - A response arriving after reset release sets spurious_resp.

## Structure
- Shared package nv_nvdla_csb_pkg holds:
  - Request bit-field position localparams (ADDR, WDAT, WRITE, NPOSTED, SRCPRIV, WRBE, LEVEL).
  - Response positions (RDATA, ERROR, TYPE) and the type encodings.
  - The FSM state enum.
- The package is reused by the CSB responders.
- One sub-module: nv_nvdla_csb_req_pack, purely combinational field packing, shared with CSB test drivers.
- The counter and FSM stay inline.

## Test plan
- Read, addr 22'h000010, target answers pd={1'b0,1'b0,32'h12345678} 3 cycles after accept → pvld 1 cycle after host accept; host_resp_valid with rdat 32'h12345678, err=0, timeout=0.
- Posted write, wdat 32'hDEADBEEF, prdy held low 4 cycles → pd stable all 4 cycles with pd[55]=0, pd[60:57]=4'hF; host_resp_valid 1 cycle after prdy, err=0.
- Non-posted write, target responds with type=0 → host_resp_err=1, rdat=0.
- Read with TIMEOUT_CYCLES=8 and no response → host_resp_timeout=1 and err=1 exactly 8 WAIT_RESP cycles after accept. A response at cycle 10 sets spurious_resp, and it stays set.
- Response on the exact expiry cycle → treated as the response, timeout=0.
- Reset pulse in WAIT_RESP → all outputs return to reset values; host_req_ready=1 on the first cycle after release.
